stream_reduce: RTL and testbench

//  Streaming group reducer that consumes a relay-stage sample stream and emits one

---
 rtl/stream_reduce.sv | 154 +++++++++++++++
 tb/tb_stream_reduce.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_reduce.sv
// Streaming group reducer: sum/min/max/count over groups closed by GROUP_LEN or in_last.
// Optional feature: define REDUCE_SAT_EN to saturate the sum result to the W-bit signed range.
module stream_reduce #(
    parameter  int W         = 32,
    parameter  int GROUP_LEN = 4,
    localparam int CNT_W     = $clog2(GROUP_LEN + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          op,
    input  logic                in_valid,
    input  logic signed [W-1:0] in,
    input  logic                in_last,
    output logic                delay_,
    output logic                valid,
    output logic signed [W-1:0] out,
    output logic [CNT_W-1:0]    out_count,
    input  logic                _delay
);

    localparam int AW = W + CNT_W;

    typedef enum logic {ACC, EMIT} state_t;

    state_t                state, state_next;
    logic signed [AW-1:0]  acc, acc_new, sample_ext;
    logic signed [W-1:0]   min_q, max_q, min_new, max_new, result, sum_res;
    logic [CNT_W-1:0]      cnt, cnt_new;
    logic [1:0]            op_q, op_new;
    logic                  first, accept, close, consume;
    logic                  valid_next, delay_next;
    logic signed [W-1:0]   out_next;
    logic [CNT_W-1:0]      count_next;

`ifdef REDUCE_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(CNT_W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(CNT_W + 1){1'b1}}, {(W - 1){1'b0}}};
`endif

    // Candidate group state assuming the current sample is accepted.
    always_comb begin
        first      = (cnt == '0);
        accept     = in_valid && !delay_ && enable && (state == ACC);
        consume    = (state == EMIT) && enable && valid && !_delay;
        sample_ext = {{CNT_W{in[W-1]}}, in};
        acc_new    = first ? sample_ext : acc + sample_ext;
        min_new    = (first || (in < min_q)) ? in : min_q;
        max_new    = (first || (in > max_q)) ? in : max_q;
        cnt_new    = first ? CNT_W'(1) : cnt + 1'b1;
        op_new     = first ? op : op_q;
        close      = in_last || (cnt_new == CNT_W'(GROUP_LEN));

`ifdef REDUCE_SAT_EN
        if (acc_new > SAT_MAX)
            sum_res = {1'b0, {(W - 1){1'b1}}};
        else if (acc_new < SAT_MIN)
            sum_res = {1'b1, {(W - 1){1'b0}}};
        else
            sum_res = acc_new[W-1:0];
`else
        sum_res = acc_new[W-1:0];
`endif

        result = sum_res;
        case (op_new)
            2'b01:   result = min_new;
            2'b10:   result = max_new;
            2'b11:   result = W'(cnt_new);
            default: result = sum_res;
        endcase
    end

    // NOTE: state is written with non-blocking assignments only; comb blocks use blocking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            min_q <= '0;
            max_q <= '0;
            cnt   <= '0;
            op_q  <= '0;
        end else if (accept) begin
            acc   <= acc_new;
            min_q <= min_new;
            max_q <= max_new;
            cnt   <= cnt_new;
            op_q  <= op_new;
        end else if (consume) begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ACC;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (accept && close) state_next = EMIT;
            EMIT:    if (consume)         state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    // Next values of the registered outputs; a result is only retired once it was seen valid.
    always_comb begin
        valid_next = valid;
        delay_next = delay_;
        out_next   = out;
        count_next = out_count;
        if (!enable) begin
            valid_next = 1'b0;
            delay_next = 1'b1;
        end else begin
            case (state)
                ACC: begin
                    valid_next = 1'b0;
                    delay_next = 1'b0;
                    if (accept && close) begin
                        valid_next = 1'b1;
                        delay_next = 1'b1;
                        out_next   = result;
                        count_next = cnt_new;
                    end
                end
                EMIT: begin
                    valid_next = !consume;
                    delay_next = !consume;
                end
                default: begin
                    valid_next = 1'b0;
                    delay_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid     <= 1'b0;
            delay_    <= 1'b0;
            out       <= '0;
            out_count <= '0;
        end else begin
            valid     <= valid_next;
            delay_    <= delay_next;
            out       <= out_next;
            out_count <= count_next;
        end
    end

endmodule

// File: tb/tb_stream_reduce.sv
// Directed testbench for stream_reduce: a W=32 instance for the main behaviour and a W=8
// instance for the sum wrap/saturation boundary (expectations follow REDUCE_SAT_EN).
module tb_stream_reduce;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [1:0]        op;
    logic              in_valid;
    logic signed [31:0] in_s;
    logic              in_last;
    logic              delay_s;
    logic              valid_s;
    logic signed [31:0] out_s;
    logic [2:0]        count_s;
    logic              hold;

    logic              in_valid8;
    logic signed [7:0] in8;
    logic              delay8;
    logic              valid8;
    logic signed [7:0] out8;
    logic [2:0]        count8;

    int checks   = 0;
    int failures = 0;

    stream_reduce #(.W(32), .GROUP_LEN(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .op(op),
        .in_valid(in_valid), .in(in_s), .in_last(in_last),
        .delay_(delay_s), .valid(valid_s), .out(out_s), .out_count(count_s),
        ._delay(hold)
    );

    stream_reduce #(.W(8), .GROUP_LEN(4)) dut8 (
        .clk(clk), .reset(reset), .enable(1'b1), .op(2'b00),
        .in_valid(in_valid8), .in(in8), .in_last(1'b0),
        .delay_(delay8), .valid(valid8), .out(out8), .out_count(count8),
        ._delay(1'b0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic signed [31:0] d, input logic l);
        in_valid = v;
        in_s     = d;
        in_last  = l;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; op = 2'b00; hold = 1'b0;
        put(1'b0, 0, 1'b0);
        in_valid8 = 1'b0; in8 = '0;
        repeat (2) tick();
        reset = 1'b0;
        checks++; if (valid_s !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_s); end
        checks++; if (out_s !== 32'sd0) begin failures++; $display("FAIL reset_out got=%0d exp=0", out_s); end
        checks++; if (count_s !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_s); end
        checks++; if (delay_s !== 1'b0) begin failures++; $display("FAIL reset_delay got=%0b exp=0", delay_s); end
        checks++; if (valid8 !== 1'b0) begin failures++; $display("FAIL reset_valid8 got=%0b exp=0", valid8); end
    endtask

    task automatic test_sum();
        op = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            put(1'b1, i, 1'b0);
            checks++; if (delay_s !== 1'b0) begin failures++; $display("FAIL sum_ready[%0d] got=%0b exp=0", i, delay_s); end
            tick();
        end
        put(1'b0, 0, 1'b0);
        checks++; if (valid_s !== 1'b1) begin failures++; $display("FAIL sum_valid got=%0b exp=1", valid_s); end
        checks++; if (out_s !== 32'sd10) begin failures++; $display("FAIL sum_out got=%0d exp=10", out_s); end
        checks++; if (count_s !== 3'd4) begin failures++; $display("FAIL sum_count got=%0d exp=4", count_s); end
        checks++; if (delay_s !== 1'b1) begin failures++; $display("FAIL sum_emit_delay got=%0b exp=1", delay_s); end
        tick();
        checks++; if (valid_s !== 1'b0) begin failures++; $display("FAIL sum_consumed got=%0b exp=0", valid_s); end
        checks++; if (delay_s !== 1'b0) begin failures++; $display("FAIL sum_release got=%0b exp=0", delay_s); end
    endtask

    task automatic test_min_latch();
        op = 2'b01;
        put(1'b1, -5, 1'b0); tick();
        op = 2'b10;  // changing op mid-group must not affect the latched op
        put(1'b1, 7, 1'b0);  tick();
        put(1'b1, 2, 1'b1);  tick();
        put(1'b0, 0, 1'b0);
        checks++; if (valid_s !== 1'b1) begin failures++; $display("FAIL min_valid got=%0b exp=1", valid_s); end
        checks++; if (out_s !== -32'sd5) begin failures++; $display("FAIL min_out got=%0d exp=-5", out_s); end
        checks++; if (count_s !== 3'd3) begin failures++; $display("FAIL min_count got=%0d exp=3", count_s); end
        tick();
        op = 2'b01;
        put(1'b1, 9, 1'b1); tick();
        put(1'b0, 0, 1'b0);
        checks++; if (out_s !== 32'sd9) begin failures++; $display("FAIL min_fresh_out got=%0d exp=9", out_s); end
        checks++; if (count_s !== 3'd1) begin failures++; $display("FAIL min_fresh_count got=%0d exp=1", count_s); end
        tick();
    endtask

    task automatic test_backpressure();
        op = 2'b10; hold = 1'b1;
        put(1'b1, 3, 1'b0);  tick();
        put(1'b1, -8, 1'b0); tick();
        put(1'b1, 6, 1'b1);  tick();
        put(1'b1, 100, 1'b1);
        checks++; if (valid_s !== 1'b1) begin failures++; $display("FAIL max_valid got=%0b exp=1", valid_s); end
        checks++; if (out_s !== 32'sd6) begin failures++; $display("FAIL max_out got=%0d exp=6", out_s); end
        checks++; if (count_s !== 3'd3) begin failures++; $display("FAIL max_count got=%0d exp=3", count_s); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (valid_s !== 1'b1) begin failures++; $display("FAIL hold_valid[%0d] got=%0b exp=1", i, valid_s); end
            checks++; if (out_s !== 32'sd6) begin failures++; $display("FAIL hold_out[%0d] got=%0d exp=6", i, out_s); end
            checks++; if (delay_s !== 1'b1) begin failures++; $display("FAIL hold_delay[%0d] got=%0b exp=1", i, delay_s); end
        end
        hold = 1'b0;
        tick();
        checks++; if (valid_s !== 1'b0) begin failures++; $display("FAIL hold_drop got=%0b exp=0", valid_s); end
        checks++; if (delay_s !== 1'b0) begin failures++; $display("FAIL hold_release got=%0b exp=0", delay_s); end
        tick();
        put(1'b0, 0, 1'b0);
        checks++; if (out_s !== 32'sd100) begin failures++; $display("FAIL after_hold_out got=%0d exp=100", out_s); end
        checks++; if (count_s !== 3'd1) begin failures++; $display("FAIL after_hold_count got=%0d exp=1", count_s); end
        tick();
    endtask

    task automatic test_count_boundary();
        op = 2'b11;
        put(1'b1, 5, 1'b0); tick();
        put(1'b0, 0, 1'b1); tick();
        checks++; if (valid_s !== 1'b0) begin failures++; $display("FAIL last_ignored got=%0b exp=0", valid_s); end
        put(1'b1, -3, 1'b0); tick();
        put(1'b1, 8, 1'b0);  tick();
        put(1'b1, 1, 1'b1);  tick();
        put(1'b0, 0, 1'b0);
        checks++; if (out_s !== 32'sd4) begin failures++; $display("FAIL count_out got=%0d exp=4", out_s); end
        checks++; if (count_s !== 3'd4) begin failures++; $display("FAIL count_count got=%0d exp=4", count_s); end
        repeat (3) tick();
        checks++; if (valid_s !== 1'b0) begin failures++; $display("FAIL single_close got=%0b exp=0", valid_s); end
        checks++; if (delay_s !== 1'b0) begin failures++; $display("FAIL single_close_delay got=%0b exp=0", delay_s); end
    endtask

    task automatic test_wrap8();
        logic signed [7:0] exp_pos, exp_neg;
`ifdef REDUCE_SAT_EN
        exp_pos = 8'sd127;
        exp_neg = -8'sd128;
`else
        exp_pos = -8'sd112;
        exp_neg = 8'sd112;
`endif
        in_valid8 = 1'b1; in8 = 8'sd100;
        repeat (4) tick();
        in_valid8 = 1'b0;
        checks++; if (valid8 !== 1'b1) begin failures++; $display("FAIL w8_valid got=%0b exp=1", valid8); end
        checks++; if (out8 !== exp_pos) begin failures++; $display("FAIL w8_pos_out got=%0d exp=%0d", out8, exp_pos); end
        checks++; if (count8 !== 3'd4) begin failures++; $display("FAIL w8_count got=%0d exp=4", count8); end
        tick();
        in_valid8 = 1'b1; in8 = -8'sd100;
        repeat (4) tick();
        in_valid8 = 1'b0;
        checks++; if (out8 !== exp_neg) begin failures++; $display("FAIL w8_neg_out got=%0d exp=%0d", out8, exp_neg); end
        tick();
    endtask

    task automatic test_async_reset();
        op = 2'b00;
        put(1'b1, 7, 1'b0); tick();
        put(1'b1, 9, 1'b0); tick();
        put(1'b0, 0, 1'b0);
        #2 reset = 1'b1;
        #1;
        checks++; if (valid_s !== 1'b0) begin failures++; $display("FAIL areset_valid got=%0b exp=0", valid_s); end
        checks++; if (out_s !== 32'sd0) begin failures++; $display("FAIL areset_out got=%0d exp=0", out_s); end
        checks++; if (count_s !== 3'd0) begin failures++; $display("FAIL areset_count got=%0d exp=0", count_s); end
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, 1, 1'b0); tick();
        end
        put(1'b0, 0, 1'b0);
        checks++; if (out_s !== 32'sd4) begin failures++; $display("FAIL areset_sum got=%0d exp=4", out_s); end
        checks++; if (count_s !== 3'd4) begin failures++; $display("FAIL areset_sum_count got=%0d exp=4", count_s); end
        tick();
    endtask

    task automatic test_enable();
        op = 2'b00;
        put(1'b1, 1, 1'b0); tick();
        put(1'b1, 2, 1'b0); tick();
        enable = 1'b0;
        put(1'b1, 50, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (delay_s !== 1'b1) begin failures++; $display("FAIL stall_delay[%0d] got=%0b exp=1", i, delay_s); end
            checks++; if (valid_s !== 1'b0) begin failures++; $display("FAIL stall_valid[%0d] got=%0b exp=0", i, valid_s); end
        end
        enable = 1'b1;
        put(1'b0, 0, 1'b0); tick();
        checks++; if (delay_s !== 1'b0) begin failures++; $display("FAIL stall_release got=%0b exp=0", delay_s); end
        put(1'b1, 3, 1'b0); tick();
        hold = 1'b1;
        put(1'b1, 4, 1'b0); tick();
        put(1'b0, 0, 1'b0);
        checks++; if (out_s !== 32'sd10) begin failures++; $display("FAIL stall_sum got=%0d exp=10", out_s); end
        checks++; if (count_s !== 3'd4) begin failures++; $display("FAIL stall_count got=%0d exp=4", count_s); end
        enable = 1'b0; tick();
        checks++; if (valid_s !== 1'b0) begin failures++; $display("FAIL emit_stall_valid got=%0b exp=0", valid_s); end
        checks++; if (delay_s !== 1'b1) begin failures++; $display("FAIL emit_stall_delay got=%0b exp=1", delay_s); end
        enable = 1'b1; hold = 1'b0; tick();
        checks++; if (valid_s !== 1'b1) begin failures++; $display("FAIL emit_resume_valid got=%0b exp=1", valid_s); end
        checks++; if (out_s !== 32'sd10) begin failures++; $display("FAIL emit_resume_out got=%0d exp=10", out_s); end
        tick();
        checks++; if (valid_s !== 1'b0) begin failures++; $display("FAIL emit_resume_consume got=%0b exp=0", valid_s); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sum();
        test_min_latch();
        test_backpressure();
        test_count_boundary();
        test_wrap8();
        test_async_reset();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
